ramp_code_dac: RTL and testbench

- Output-direction counterpart of the ramp-compare TDC ADC path: takes offset-binary codes of the same width the ADC produces and turns them back into an analog level.
- Method: first-order delta-sigma bitstream on one FPGA pin, followed by an external RC filter.
- Samples arrive on a valid/ready stream, are buffered in a small FIFO, and are consumed at a fixed sample rate derived from a clock divider.
- Used for loopback calibration of the ADC chain and for generating test stimuli.

---
 rtl/ramp_code_dac_pkg.sv | 11 +
 rtl/ramp_code_dac_if.sv | 15 +
 rtl/ramp_dac_fifo.sv | 60 ++++++
 rtl/ramp_code_dac.sv | 108 ++++++++++
 tb/tb_ramp_code_dac.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ramp_code_dac_pkg.sv
// Shared definitions for the ramp-code DAC: code width common with the
// ramp-compare ADC top, default sample divider and FIFO depth.
package ramp_code_dac_pkg;

    localparam int unsigned DAC_CODE_BITS  = 10;
    localparam int unsigned DAC_SAMPLE_DIV = 1024;
    localparam int unsigned DAC_FIFO_DEPTH = 4;

    typedef logic [DAC_CODE_BITS-1:0] code_t;

endpackage

// File: rtl/ramp_code_dac_if.sv
// Valid/ready sample stream carrying offset-binary codes into the DAC.
interface ramp_code_dac_if
    import ramp_code_dac_pkg::*;
#(
    parameter int unsigned W = DAC_CODE_BITS
) ();

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_code;

    modport master (output s_valid, output s_code, input s_ready);
    modport slave  (input s_valid, input s_code, output s_ready);

endinterface

// File: rtl/ramp_dac_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible
// on o_data while the FIFO is not empty.
module ramp_dac_fifo #(
    parameter  int unsigned WIDTH = 10,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ramp_code_dac.sv
// Sample-rate code DAC: FIFO-buffered codes drive a first-order delta-sigma
// bitstream on one pin, to be smoothed by an external RC filter.
module ramp_code_dac
    import ramp_code_dac_pkg::*;
#(
    parameter  int unsigned CODE_BITS  = DAC_CODE_BITS,
    parameter  int unsigned SAMPLE_DIV = DAC_SAMPLE_DIV,
    parameter  int unsigned FIFO_DEPTH = DAC_FIFO_DEPTH,
    localparam int unsigned LVL_BITS   = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned DIV_BITS   = $clog2(SAMPLE_DIV)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    ramp_code_dac_if.slave      s_if,
    input  logic                clear_underrun,
    output logic                dac_out,
    output logic                sample_strobe,
    output logic                underrun,
    output logic [LVL_BITS-1:0] fifo_level
);

    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(SAMPLE_DIV - 1);

    logic [DIV_BITS-1:0]  r_div;
    logic [CODE_BITS-1:0] r_cur_code;
    logic [CODE_BITS-1:0] r_acc;
    logic                 r_dac;
    logic                 r_strobe;
    logic                 r_underrun;

    logic                 w_tick;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CODE_BITS-1:0] w_head;
    logic [CODE_BITS:0]   w_sum;

    assign s_if.s_ready = !w_full;
    assign w_push       = s_if.s_valid && !w_full;
    assign w_tick       = enable && (r_div == DIV_LAST);
    assign w_pop        = w_tick && !w_empty;
    assign w_sum        = {1'b0, r_acc} + {1'b0, r_cur_code};

    ramp_dac_fifo #(
        .WIDTH (CODE_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_data  (s_if.s_code),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (!enable || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_BITS'(1);
        end
    end

    // An empty tick keeps the previous code playing and flags the gap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_code <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe <= w_pop;
            if (w_pop) begin
                r_cur_code <= w_head;
            end
            if (w_tick && w_empty) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Carry out of the phase accumulator is the output bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else if (!enable) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else begin
            r_acc <= w_sum[CODE_BITS-1:0];
            r_dac <= w_sum[CODE_BITS];
        end
    end

    assign dac_out       = r_dac;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_ramp_code_dac.sv
// Directed bench for ramp_code_dac: queued codes are checked by counting
// output ones over each sample window.
module tb_ramp_code_dac;
    import ramp_code_dac_pkg::*;

    localparam int unsigned CB    = 10;
    localparam int          DIV   = 1024;
    localparam int unsigned DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       clear_underrun;
    logic       dac_out;
    logic       sample_strobe;
    logic       underrun;
    logic [2:0] fifo_level;

    int    total = 0;
    int    bad   = 0;
    code_t exp_q[$];
    code_t last_code = '0;

    ramp_code_dac_if #(.W(CB)) s_if ();

    ramp_code_dac #(
        .CODE_BITS  (CB),
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_if           (s_if),
        .clear_underrun (clear_underrun),
        .dac_out        (dac_out),
        .sample_strobe  (sample_strobe),
        .underrun       (underrun),
        .fifo_level     (fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input code_t c, input bit exp_acc);
        s_if.s_valid = 1'b1;
        s_if.s_code  = c;
        chk("s_ready", 32'(s_if.s_ready), 32'(exp_acc));
        if (exp_acc) exp_q.push_back(c);
        step();
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int exp_n, input int exp_ones);
        int n = 0;
        int ones = 0;
        bit seen = 1'b0;
        while (!seen && n < exp_n + 8) begin
            step();
            n++;
            if (dac_out === 1'b1) ones++;
            if (sample_strobe === 1'b1) seen = 1'b1;
        end
        chk({tag, "_lat"}, n, exp_n);
        if (exp_ones >= 0) chk({tag, "_ones"}, ones, exp_ones);
        if (seen && exp_q.size() > 0) last_code = exp_q.pop_front();
    endtask

    // Starts on a strobe cycle; ends on the cycle after the next tick.
    task automatic window(input string tag, input int clr_a, input int clr_b,
                          input bit push_tick, input code_t pcode,
                          input bit exp_next, input bit chk_alt);
        int    ones = 0;
        code_t code = last_code;
        for (int o = 0; o < DIV; o++) begin
            clear_underrun = (o == clr_a) || (o == clr_b);
            if (push_tick && o == DIV - 1) begin
                s_if.s_valid = 1'b1;
                s_if.s_code  = pcode;
                chk({tag, "_tick_ready"}, 32'(s_if.s_ready), 1);
                exp_q.push_back(pcode);
            end
            step();
            clear_underrun = 1'b0;
            s_if.s_valid   = 1'b0;
            if (dac_out === 1'b1) ones++;
            if (chk_alt && o < 8) chk({tag, "_alt"}, 32'(dac_out), 32'(((o + 1) % 2) == 0));
            if (o == clr_a && o != DIV - 1) chk({tag, "_clr"}, 32'(underrun), 0);
        end
        chk({tag, "_ones"}, ones, 32'(code));
        chk({tag, "_strobe"}, 32'(sample_strobe), 32'(exp_next));
        if (exp_next) begin
            if (exp_q.size() > 0) last_code = exp_q.pop_front();
        end else begin
            chk({tag, "_underrun"}, 32'(underrun), 1);
        end
    endtask

    initial begin
        int hits_dac;
        int hits_stb;
        int n;

        reset_n        = 1'b0;
        enable         = 1'b0;
        clear_underrun = 1'b0;
        s_if.s_valid   = 1'b0;
        s_if.s_code    = '0;
        repeat (2) step();

        // Push attempted while reset is held must be dropped.
        s_if.s_valid = 1'b1;
        s_if.s_code  = 10'd99;
        step();
        chk("rst_level",    32'(fifo_level),    0);
        chk("rst_dac",      32'(dac_out),       0);
        chk("rst_strobe",   32'(sample_strobe), 0);
        chk("rst_underrun", 32'(underrun),      0);
        chk("rst_ready",    32'(s_if.s_ready),  1);
        s_if.s_valid = 1'b0;
        reset_n      = 1'b1;
        step();
        chk("post_rst_level", 32'(fifo_level), 0);

        push(10'd256, 1'b1);
        push(10'd512, 1'b1);
        push(10'd0,   1'b1);
        chk("lvl3",   32'(fifo_level),   3);
        chk("ready3", 32'(s_if.s_ready), 1);
        hits_dac = 0;
        hits_stb = 0;
        repeat (20) begin
            step();
            if (dac_out !== 1'b0) hits_dac++;
            if (sample_strobe !== 1'b0) hits_stb++;
        end
        chk("idle_dac",    hits_dac, 0);
        chk("idle_strobe", hits_stb, 0);

        push(10'd1023, 1'b1);
        chk("full_level", 32'(fifo_level),   4);
        push(10'd5, 1'b0);
        push(10'd6, 1'b0);
        chk("ovf_level",  32'(fifo_level),   4);

        enable = 1'b1;
        wait_strobe("tick1", DIV, 0);
        chk("tick1_level", 32'(fifo_level),   3);
        chk("tick1_ready", 32'(s_if.s_ready), 1);

        window("w256",  -1, -1, 1'b0, '0, 1'b1, 1'b0);
        window("w512",  -1, -1, 1'b0, '0, 1'b1, 1'b1);
        window("w0",    -1, -1, 1'b0, '0, 1'b1, 1'b0);
        window("w1023", -1, -1, 1'b0, '0, 1'b0, 1'b0);
        window("wur",   500, DIV - 1, 1'b1, 10'd768, 1'b0, 1'b0);
        chk("wur_level", 32'(fifo_level), 1);
        window("wheld", -1, -1, 1'b0, '0, 1'b1, 1'b0);
        window("w768",  -1, -1, 1'b0, '0, 1'b0, 1'b0);

        push(10'd100, 1'b1);
        push(10'd200, 1'b1);
        chk("pre_rst_level", 32'(fifo_level), 2);
        n = 0;
        while (dac_out !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        chk("pre_rst_dac", 32'(dac_out), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_level",    32'(fifo_level),    0);
        chk("mid_rst_dac",      32'(dac_out),       0);
        chk("mid_rst_underrun", 32'(underrun),      0);
        chk("mid_rst_strobe",   32'(sample_strobe), 0);
        exp_q.delete();
        last_code = '0;
        repeat (2) step();
        reset_n = 1'b1;
        push(10'd384, 1'b1);
        wait_strobe("post_rst", DIV - 1, 0);
        window("w384", -1, -1, 1'b0, '0, 1'b0, 1'b0);

        s_if.s_valid = 1'b1;
        s_if.s_code  = 10'd640;
        chk("dis_ready", 32'(s_if.s_ready), 1);
        exp_q.push_back(10'd640);
        enable = 1'b0;
        step();
        s_if.s_valid = 1'b0;
        chk("dis_dac", 32'(dac_out), 0);
        hits_dac = 0;
        hits_stb = 0;
        repeat (1500) begin
            step();
            if (dac_out !== 1'b0) hits_dac++;
            if (sample_strobe !== 1'b0) hits_stb++;
        end
        chk("dis_dac_hold", hits_dac, 0);
        chk("dis_no_tick",  hits_stb, 0);
        chk("dis_level",    32'(fifo_level), 1);
        chk("dis_underrun", 32'(underrun),   1);
        clear_underrun = 1'b1;
        step();
        clear_underrun = 1'b0;
        chk("clr_only", 32'(underrun), 0);

        enable = 1'b1;
        wait_strobe("reen", DIV, -1);
        window("w640", -1, -1, 1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
